// File: rtl/tlc5615_tx.sv
// TLC5615 DAC serial transmitter: one 10-bit sample -> one 12-bit cs_n frame, MSB first, registered pins.
// Latency: cs_n falls two clk24 cycles after acceptance; backpressure: in_ready low while the one-entry buffer is full.
module tlc5615_tx #(
  parameter int CLK_DIV = 6,
  parameter int CS_IDLE = 4
) (
  input  logic       clk24,
  input  logic       reset,
  input  logic [9:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       dac_sclk,
  output logic       dac_din,
  output logic       dac_cs_n,
  output logic       frame_done,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [4:0] GAP_LAST = 5'(CS_IDLE - 1);

  state_t      state, state_nxt;
  logic [7:0]  div_cnt, div_nxt;
  logic [4:0]  half_cnt, half_nxt;
  logic [11:0] shifter, shifter_nxt;
  logic [9:0]  buf_dat;
  logic        buf_full;
  logic        tick;
  logic        unload;
  logic        sclk_c, din_c, cs_n_c, done_c, busy_c;

  assign buf_full = !in_ready;
  assign tick     = (div_cnt == DIV_LAST);

  always_comb begin
    state_nxt   = state;
    div_nxt     = 8'd0;
    half_nxt    = half_cnt;
    shifter_nxt = shifter;
    unload      = 1'b0;
    sclk_c      = 1'b0;
    din_c       = 1'b0;
    cs_n_c      = 1'b1;
    done_c      = 1'b0;
    busy_c      = 1'b1;
    if (state != IDLE) begin
      div_nxt = tick ? 8'd0 : div_cnt + 8'd1;
    end
    case (state)
      IDLE: begin
        busy_c = 1'b0;
        if (buf_full) begin
          shifter_nxt = {buf_dat, 2'b00};
          unload      = 1'b1;
          half_nxt    = 5'd0;
          state_nxt   = SETUP;
        end
      end
      SETUP: begin
        cs_n_c = 1'b0;
        din_c  = shifter[11];
        if (tick) begin
          half_nxt  = 5'd0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        // even half-periods are sclk-high; the shift happens as sclk falls
        cs_n_c = 1'b0;
        din_c  = shifter[11];
        sclk_c = !half_cnt[0];
        if (tick) begin
          if (!half_cnt[0]) begin
            shifter_nxt = {shifter[10:0], 1'b0};
          end
          if (half_cnt == 5'd23) begin
            half_nxt  = 5'd0;
            state_nxt = GAP;
          end else begin
            half_nxt = half_cnt + 5'd1;
          end
        end
      end
      GAP: begin
        done_c = (half_cnt == 5'd0) && (div_cnt == 8'd0);
        if (tick) begin
          if (half_cnt == GAP_LAST) begin
            state_nxt = IDLE;
          end else begin
            half_nxt = half_cnt + 5'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk24) begin
    if (reset) begin
      state      <= IDLE;
      div_cnt    <= 8'd0;
      half_cnt   <= 5'd0;
      shifter    <= 12'd0;
      buf_dat    <= 10'd0;
      in_ready   <= 1'b1;
      dac_sclk   <= 1'b0;
      dac_din    <= 1'b0;
      dac_cs_n   <= 1'b1;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state    <= state_nxt;
      div_cnt  <= div_nxt;
      half_cnt <= half_nxt;
      shifter  <= shifter_nxt;
      if (in_valid && in_ready) begin
        buf_dat  <= in_data;
        in_ready <= 1'b0;
      end else if (unload) begin
        in_ready <= 1'b1;
      end
      dac_sclk   <= sclk_c;
      dac_din    <= din_c;
      dac_cs_n   <= cs_n_c;
      frame_done <= done_c;
      busy       <= busy_c;
    end
  end

endmodule

// File: tb/tb_tlc5615_tx.sv
// Bench for tlc5615_tx: default build and a CLK_DIV=1/CS_IDLE=1 build side by side against a frame-timeline model.
module tb_tlc5615_tx;
  localparam int DA = 6, GA = 4, DB = 1, GB = 1;
  localparam longint DV [2] = '{DA, DB};
  localparam longint GV [2] = '{GA, GB};

  logic       clk24 = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] dat [2];
  logic       vld [2];
  logic       rdy [2], sclk [2], din [2], csn [2], done [2], busy [2];

  int     vectors = 0, miscompares = 0;
  longint cyc = 0;
  bit     chk_en = 1'b0;

  always #5 clk24 = ~clk24;

  tlc5615_tx #(.CLK_DIV(DA), .CS_IDLE(GA)) dut_a (
    .clk24(clk24), .reset(reset), .in_data(dat[0]), .in_valid(vld[0]), .in_ready(rdy[0]),
    .dac_sclk(sclk[0]), .dac_din(din[0]), .dac_cs_n(csn[0]), .frame_done(done[0]), .busy(busy[0]));

  tlc5615_tx #(.CLK_DIV(DB), .CS_IDLE(GB)) dut_b (
    .clk24(clk24), .reset(reset), .in_data(dat[1]), .in_valid(vld[1]), .in_ready(rdy[1]),
    .dac_sclk(sclk[1]), .dac_din(din[1]), .dac_cs_n(csn[1]), .frame_done(done[1]), .busy(busy[1]));

  // model: buffer contents plus the start cycle and word of the current frame
  logic        m_full [2];
  logic [9:0]  m_buf [2];
  logic [11:0] m_word [2];
  longint      m_fstart [2] = '{-100000, -100000};
  longint      m_next [2];

  // pin monitor results
  bit          prev_cs [2] = '{1'b1, 1'b1};
  bit          prev_sclk [2] = '{1'b0, 1'b0};
  bit          prev_busy [2] = '{1'b0, 1'b0};
  longint      fall_cyc [2], rise_cyc [2], busy_fall [2], last_sr [2], sclk_period [2];
  int          nb [2], nfall [2], nfrm [2], done_cnt [2], sclk_edges [2];
  logic [11:0] capt [2];
  logic [11:0] frm [2][64];
  longint      low_r [2][64], gap_r [2][64];

  task automatic check(input string name, input longint got, input longint want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic model_step();
    longint n;
    n = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_full[i]   = 1'b0;
        m_fstart[i] = -100000;
        m_next[i]   = 0;
      end else if (m_full[i] && n >= m_next[i]) begin
        m_word[i]   = {m_buf[i], 2'b00};
        m_fstart[i] = n + 1;
        m_next[i]   = n + 1 + 25 * DV[i] + GV[i] * DV[i];
        m_full[i]   = 1'b0;
      end else if (vld[i] && !m_full[i]) begin
        m_buf[i]  = dat[i];
        m_full[i] = 1'b1;
      end
    end
  endtask

  // {in_ready, cs_n, sclk, din, busy, frame_done} expected after the current edge
  function automatic logic [5:0] model_out(input int i);
    longint k, d, h;
    logic [3:0] bi;
    logic [5:0] o;
    d = DV[i];
    k = cyc - m_fstart[i];
    o = {!m_full[i], 5'b10000};
    if (k >= 0 && k < 25 * d) begin
      h = k / d;
      bi = 4'(11 - h / 2);
      o[4] = 1'b0;
      o[3] = h[0];
      o[2] = m_word[i][bi];
      o[1] = 1'b1;
    end else if (k >= 25 * d && k < (25 + GV[i]) * d) begin
      o[1] = 1'b1;
      o[0] = (k == 25 * d);
    end
    return o;
  endfunction

  task automatic monitor(input int i);
    if (prev_cs[i] && !csn[i]) begin
      gap_r[i][nfall[i] % 64] = cyc - rise_cyc[i];
      fall_cyc[i] = cyc;
      nfall[i]++;
      capt[i] = 12'd0;
      nb[i] = 0;
    end
    if (!prev_cs[i] && csn[i]) begin
      frm[i][nfrm[i] % 64] = capt[i];
      low_r[i][nfrm[i] % 64] = cyc - fall_cyc[i];
      rise_cyc[i] = cyc;
      nfrm[i]++;
    end
    if (sclk[i] != prev_sclk[i]) sclk_edges[i]++;
    if (!prev_sclk[i] && sclk[i]) begin
      capt[i] = {capt[i][10:0], din[i]};
      nb[i]++;
      sclk_period[i] = cyc - last_sr[i];
      last_sr[i] = cyc;
    end
    if (prev_busy[i] && !busy[i]) busy_fall[i] = cyc;
    if (done[i]) done_cnt[i]++;
    prev_cs[i] = csn[i];
    prev_sclk[i] = sclk[i];
    prev_busy[i] = busy[i];
  endtask

  task automatic run_monitor();
    logic [5:0] got, want;
    forever begin
      @(posedge clk24);
      model_step();
      cyc++;
      #1;
      if (chk_en) begin
        for (int i = 0; i < 2; i++) begin
          got  = {rdy[i], csn[i], sclk[i], din[i], busy[i], done[i]};
          want = model_out(i);
          vectors++;
          if (got !== want) begin
            miscompares++;
            $display("FAIL pins dut%0d cycle %0d {rdy,cs_n,sclk,din,busy,done}: got %b, expected %b",
                     i, cyc, got, want);
          end
          monitor(i);
        end
      end
    end
  endtask

  // call at a negedge; returns at the negedge after the accepting edge
  task automatic send(input int i, input logic [9:0] d, input bit keep, output int waited, output longint acc);
    int w;
    w = 0;
    vld[i] = 1'b1;
    dat[i] = d;
    while (!rdy[i] && w < 5000) begin
      @(negedge clk24);
      w++;
    end
    check("in_ready_within_bound", longint'(rdy[i]), 1);
    waited = w;
    acc = cyc + 1;
    @(negedge clk24);
    if (!keep) vld[i] = 1'b0;
  endtask

  task automatic wait_frames(input int i, input int n);
    int w;
    w = 0;
    while (nfrm[i] < n && w < 20000) begin
      @(negedge clk24);
      w++;
    end
    check("frames_seen", longint'(nfrm[i]), longint'(n));
  endtask

  task automatic rand_stream(input int i, input int n);
    int w;
    longint a;
    bit keep;
    for (int j = 0; j < n; j++) begin
      keep = (j < n - 1) && ($urandom_range(0, 2) == 0);
      send(i, 10'($urandom_range(0, 1023)), keep, w, a);
      if (!keep) repeat ($urandom_range(0, 250)) @(negedge clk24);
    end
  endtask

  initial begin
    int w, base, nf, e0, d0, b0, b1;
    longint acc;
    vld = '{1'b0, 1'b0};
    dat = '{10'd0, 10'd0};
    fork
      run_monitor();
    join_none
    repeat (2) @(negedge clk24);
    chk_en = 1'b1;
    @(negedge clk24);
    reset = 1'b0;

    // idle after reset
    e0 = sclk_edges[0] + sclk_edges[1];
    repeat (1000) @(negedge clk24);
    check("idle_sclk_edges", longint'(sclk_edges[0] + sclk_edges[1] - e0), 0);
    check("idle_cs_n", longint'(csn[0]), 1);
    check("idle_din", longint'(din[0]), 0);
    check("idle_in_ready", longint'(rdy[0]), 1);
    check("idle_busy", longint'(busy[0]), 0);

    // single sample 0x2A5
    base = nfrm[0];
    d0 = done_cnt[0];
    send(0, 10'h2A5, 1'b0, w, acc);
    wait_frames(0, base + 1);
    check("cs_fall_latency", fall_cyc[0] - acc, 2);
    check("bits_2A5", longint'(frm[0][base % 64]), longint'(12'hA94));
    check("cs_low_cycles", low_r[0][base % 64], 150);
    w = 0;
    while (busy[0] && w < 1000) begin
      @(negedge clk24);
      w++;
    end
    check("busy_fall_after_cs_rise", busy_fall[0] - rise_cyc[0], 24);
    check("frame_done_pulses", longint'(done_cnt[0] - d0), 1);

    // three samples with in_valid held high
    base = nfrm[0];
    send(0, 10'h3FF, 1'b1, w, acc);
    check("in_ready_low_when_full", longint'(rdy[0]), 0);
    send(0, 10'h000, 1'b1, w, acc);
    send(0, 10'h155, 1'b0, w, acc);
    wait_frames(0, base + 3);
    check("b2b_word0", longint'(frm[0][base % 64]), longint'(12'hFFC));
    check("b2b_word1", longint'(frm[0][(base + 1) % 64]), 0);
    check("b2b_word2", longint'(frm[0][(base + 2) % 64]), longint'(12'h554));
    check("b2b_gap1", gap_r[0][(base + 1) % 64], 25);
    check("b2b_gap2", gap_r[0][(base + 2) % 64], 25);

    // refill while shifting
    repeat (60) @(negedge clk24);
    base = nfrm[0];
    send(0, 10'h111, 1'b0, w, acc);
    w = 0;
    while (!(nfall[0] > base && nb[0] >= 3) && w < 2000) begin
      @(negedge clk24);
      w++;
    end
    send(0, 10'h222, 1'b0, w, acc);
    check("accept_in_shift_wait", longint'(w), 0);
    wait_frames(0, base + 2);
    check("shift_refill_word0", longint'(frm[0][base % 64]), longint'(12'h444));
    check("shift_refill_word1", longint'(frm[0][(base + 1) % 64]), longint'(12'h888));
    check("shift_refill_gap", gap_r[0][(base + 1) % 64], 25);

    // reset at the 5th sclk rise with a sample buffered
    repeat (60) @(negedge clk24);
    base = nfall[0];
    send(0, 10'h3C3, 1'b0, w, acc);
    send(0, 10'h0AA, 1'b0, w, acc);
    w = 0;
    while (!(nfall[0] > base && nb[0] >= 5) && w < 2000) begin
      @(negedge clk24);
      w++;
    end
    check("reached_5th_rise", longint'(nb[0]), 5);
    reset = 1'b1;
    @(negedge clk24);
    check("rst_cs_n", longint'(csn[0]), 1);
    check("rst_sclk", longint'(sclk[0]), 0);
    check("rst_din", longint'(din[0]), 0);
    check("rst_in_ready", longint'(rdy[0]), 1);
    reset = 1'b0;
    nf = nfall[0];
    repeat (300) @(negedge clk24);
    check("buffer_discarded", longint'(nfall[0] - nf), 0);
    base = nfrm[0];
    send(0, 10'h2C9, 1'b0, w, acc);
    wait_frames(0, base + 1);
    check("post_reset_word", longint'(frm[0][base % 64]), longint'(12'hB24));
    check("post_reset_low", low_r[0][base % 64], 150);

    // CLK_DIV=1, CS_IDLE=1 build
    base = nfrm[1];
    send(1, 10'h001, 1'b0, w, acc);
    wait_frames(1, base + 1);
    check("div1_cs_low", low_r[1][base % 64], 25);
    check("div1_word", longint'(frm[1][base % 64]), longint'(12'h004));
    check("div1_sclk_period", sclk_period[1], 2);

    // randomized traffic on both builds
    repeat (60) @(negedge clk24);
    b0 = nfrm[0];
    b1 = nfrm[1];
    fork
      rand_stream(0, 12);
      rand_stream(1, 12);
    join
    wait_frames(0, b0 + 12);
    wait_frames(1, b1 + 12);
    w = 0;
    while ((busy[0] || busy[1] || !rdy[0] || !rdy[1]) && w < 10000) begin
      @(negedge clk24);
      w++;
    end
    check("rand_frames_a", longint'(nfrm[0] - b0), 12);
    check("rand_frames_b", longint'(nfrm[1] - b1), 12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
